// File: rtl/uart_in_pkg.sv
// Shared types and constants for the host-to-core byte-stream loader endpoint.
package uart_in_pkg;

  typedef enum logic [1:0] {S_HELLO, S_WAIT, S_DRAIN, S_RUN} hello_state_t;

  localparam logic [7:0] READY_BYTE_DEF = 8'haa;
  localparam int         SLD_BYTES      = 1300;

endpackage

// File: rtl/uart_in_buffer_byte_fifo.sv
// Circular byte FIFO with a synchronous-read memory and a registered pop port.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_req,
  input  logic [7:0]            push_data,
  input  logic                  pop_req,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [7:0]            r_rd_data;
  logic                  r_rd_valid;
  logic                  r_overflow;

  logic w_pop;
  logic w_push;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_FULL);
  assign count    = r_count;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign overflow = r_overflow;

  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_pop  = pop_req & ~empty;
  assign w_push = push_req & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + PTR_ONE;
      end
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (push_req && !w_push) begin
        r_overflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_in_buffer.sv
// Loader endpoint: sends READY_BYTE once after reset, buffers uart_rx bytes for the CPU.
// Define FERR_DROP_EN to discard bytes that arrive with a framing error.
module uart_in_buffer
  import uart_in_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 11,
  parameter logic [7:0] READY_BYTE = READY_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_ready,
  input  logic                rx_ferr,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_busy,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic                ferr_seen
);

  hello_state_t r_state;
  logic         r_tx_start;
  logic         r_ferr_seen;
  logic         w_push_req;

  assign tx_data   = READY_BYTE;
  assign tx_start  = r_tx_start;
  assign ferr_seen = r_ferr_seen;

`ifdef FERR_DROP_EN
  assign w_push_req = rx_ready & ~rx_ferr;
`else
  assign w_push_req = rx_ready;
`endif

  // Handshake: one start pulse, then follow tx_busy high and low before idling for good.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HELLO;
      r_tx_start  <= 1'b0;
      r_ferr_seen <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_HELLO: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT:  if (tx_busy)  r_state <= S_DRAIN;
        S_DRAIN: if (!tx_busy) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
      if (rx_ready && rx_ferr) begin
        r_ferr_seen <= 1'b1;
      end
    end
  end

  byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_req (w_push_req),
    .push_data(rx_data),
    .pop_req  (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_uart_in_buffer.sv
// Bench for uart_in_buffer: a 2048-deep and an 8-deep instance checked against a queue model.
module tb_uart_in_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH_LOG2 = 11
  logic        rst_a = 1'b1, rxr_a = 1'b0, rxf_a = 1'b0, busy_a = 1'b0, rden_a = 1'b0;
  logic [7:0]  rxd_a = 8'h00;
  logic [7:0]  td_a, rdd_a;
  logic        ts_a, rdv_a, emp_a, ful_a, ovf_a, fe_a;
  logic [11:0] cnt_a;

  // Instance B: DEPTH_LOG2 = 3
  logic        rst_b = 1'b1, rxr_b = 1'b0, rxf_b = 1'b0, busy_b = 1'b0, rden_b = 1'b0;
  logic [7:0]  rxd_b = 8'h00;
  logic [7:0]  td_b, rdd_b;
  logic        ts_b, rdv_b, emp_b, ful_b, ovf_b, fe_b;
  logic [3:0]  cnt_b;

  uart_in_buffer #(.DEPTH_LOG2(11), .READY_BYTE(8'haa)) u_a (
    .clk(clk), .rst(rst_a), .rx_data(rxd_a), .rx_ready(rxr_a), .rx_ferr(rxf_a),
    .tx_data(td_a), .tx_start(ts_a), .tx_busy(busy_a), .rd_en(rden_a),
    .rd_data(rdd_a), .rd_valid(rdv_a), .empty(emp_a), .full(ful_a),
    .count(cnt_a), .overflow(ovf_a), .ferr_seen(fe_a));

  uart_in_buffer #(.DEPTH_LOG2(3), .READY_BYTE(8'haa)) u_b (
    .clk(clk), .rst(rst_b), .rx_data(rxd_b), .rx_ready(rxr_b), .rx_ferr(rxf_b),
    .tx_data(td_b), .tx_start(ts_b), .tx_busy(busy_b), .rd_en(rden_b),
    .rd_data(rdd_b), .rd_valid(rdv_b), .empty(emp_b), .full(ful_b),
    .count(cnt_b), .overflow(ovf_b), .ferr_seen(fe_b));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Reference model: byte queues plus "hello already sent" flags.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         m_live[2], m_sent[2], m_ts[2], m_rdv[2], m_ovf[2], m_fe[2];
  logic [7:0] m_rdd[2];

  task automatic model_step(input int k, input bit rst, input bit busy, input bit rxr,
                            input bit rxf, input logic [7:0] rxd, input bit rden);
    int  depth;
    int  sz;
    bit  accept;
    depth = (k == 0) ? 2048 : 8;
    sz    = (k == 0) ? qa.size() : qb.size();
    if (rst) begin
      if (k == 0) qa.delete(); else qb.delete();
      m_live[k] = 1; m_sent[k] = 0; m_ts[k] = 0; m_rdv[k] = 0;
      m_rdd[k] = 8'h00; m_ovf[k] = 0; m_fe[k] = 0;
    end else begin
      m_ts[k] = !m_sent[k] && !busy;
      if (m_ts[k]) m_sent[k] = 1;
      m_rdv[k] = 0;
      if (rden && sz > 0) begin
        m_rdd[k] = (k == 0) ? qa.pop_front() : qb.pop_front();
        m_rdv[k] = 1;
        sz--;
      end
      accept = rxr;
`ifdef FERR_DROP_EN
      accept = rxr && !rxf;
`endif
      if (accept) begin
        if (sz < depth) begin
          if (k == 0) qa.push_back(rxd); else qb.push_back(rxd);
        end else begin
          m_ovf[k] = 1;
        end
      end
      if (rxr && rxf) m_fe[k] = 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, busy_a, rxr_a, rxf_a, rxd_a, rden_a);
    model_step(1, rst_b, busy_b, rxr_b, rxf_b, rxd_b, rden_b);
  end

  always @(negedge clk) begin
    if (m_live[0]) begin
      chk("a.tx_start", ts_a, m_ts[0]);
      chk("a.tx_data", td_a, 8'haa);
      chk("a.rd_valid", rdv_a, m_rdv[0]);
      chk("a.rd_data", rdd_a, m_rdd[0]);
      chk("a.count", cnt_a, qa.size());
      chk("a.empty", emp_a, qa.size() == 0);
      chk("a.full", ful_a, qa.size() == 2048);
      chk("a.overflow", ovf_a, m_ovf[0]);
      chk("a.ferr_seen", fe_a, m_fe[0]);
    end
    if (m_live[1]) begin
      chk("b.tx_start", ts_b, m_ts[1]);
      chk("b.tx_data", td_b, 8'haa);
      chk("b.rd_valid", rdv_b, m_rdv[1]);
      chk("b.rd_data", rdd_b, m_rdd[1]);
      chk("b.count", cnt_b, qb.size());
      chk("b.empty", emp_b, qb.size() == 0);
      chk("b.full", ful_b, qb.size() == 8);
      chk("b.overflow", ovf_b, m_ovf[1]);
      chk("b.ferr_seen", fe_b, m_fe[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the instance-A hello pulse; returns edges taken (99 on timeout).
  task automatic wait_hello_a(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ts_a && lat < 20);
    if (!ts_a) lat = 99;
  endtask

  initial begin
    int lat;
    int pulses;
    logic [7:0] exp_b;

    // Reset state
    tick(); tick();
    chk("rst.count", cnt_a, 0);
    chk("rst.empty", emp_a, 1);
    chk("rst.full", ful_a, 0);
    chk("rst.tx_start", ts_a, 0);
    chk("rst.tx_data", td_a, 8'haa);
    chk("rst.rd_data", rdd_a, 8'h00);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Hello with tx_busy low, then a busy cycle, then a long quiet stretch
    wait_hello_a(lat);
    chk("hello.latency", lat, 1);
    chk("hello.byte", td_a, 8'haa);
    tick();
    chk("hello.one_cycle", ts_a, 0);
    busy_a = 1'b1;
    repeat (3) tick();
    busy_a = 1'b0;
    pulses = 0;
    repeat (10000) begin
      tick();
      pulses += int'(ts_a);
    end
    chk("hello.no_repeat", pulses, 0);

    // Hello held off by tx_busy for 50 cycles
    rst_a = 1'b1; busy_a = 1'b1;
    tick();
    rst_a = 1'b0;
    pulses = 0;
    repeat (50) begin
      tick();
      pulses += int'(ts_a);
    end
    chk("busy_hold.no_pulse", pulses, 0);
    busy_a = 1'b0;
    wait_hello_a(lat);
    chk("busy_hold.latency", lat, 1);
    busy_a = 1'b1; tick(); tick();
    busy_a = 1'b0; tick();

    // 1300-byte stream, then drain
    for (int i = 0; i < 1300; i++) begin
      rxd_a = 8'(i); rxr_a = 1'b1;
      tick();
    end
    rxr_a = 1'b0;
    tick();
    chk("stream.count", cnt_a, 1300);
    rden_a = 1'b1;
    for (int i = 0; i < 1300; i++) begin
      tick();
      chk("stream.rd_valid", rdv_a, 1);
      chk("stream.rd_data", rdd_a, 32'(i & 8'hff));
    end
    rden_a = 1'b0;
    tick();
    chk("stream.count_end", cnt_a, 0);
    chk("stream.empty_end", emp_a, 1);
    chk("stream.rd_valid_end", rdv_a, 0);

    // 8-deep: overfill by one, drain, pop on empty
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rxd_b = 8'h10 + 8'(i); rxr_b = 1'b1;
      tick();
      if (i == 7) chk("small.full_at_8", ful_b, 1);
    end
    rxr_b = 1'b0;
    chk("small.count", cnt_b, 8);
    chk("small.overflow", ovf_b, 1);
    rden_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("small.pop", rdd_b, 32'(8'h10 + i));
    end
    tick();
    chk("small.empty_pop_valid", rdv_b, 0);
    chk("small.empty_pop_hold", rdd_b, 8'h17);
    rden_b = 1'b0;

    // 8-deep full: simultaneous push/pop for 20 cycles
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rxd_b = 8'h20 + 8'(i); rxr_b = 1'b1;
      tick();
    end
    rden_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rxd_b = 8'h40 + 8'(i);
      tick();
      exp_b = (i < 8) ? 8'h20 + 8'(i) : 8'h40 + 8'(i - 8);
      chk("wrap.pop", rdd_b, exp_b);
      chk("wrap.count", cnt_b, 8);
    end
    rxr_b = 1'b0; rden_b = 1'b0;
    tick();
    chk("wrap.overflow", ovf_b, 0);

    // Framing error on instance A
    rxd_a = 8'h5a; rxr_a = 1'b1; rxf_a = 1'b1;
    tick();
    rxr_a = 1'b0; rxf_a = 1'b0;
    chk("ferr.seen", fe_a, 1);
`ifdef FERR_DROP_EN
    chk("ferr.count", cnt_a, 0);
`else
    chk("ferr.count", cnt_a, 1);
    rden_a = 1'b1; tick(); rden_a = 1'b0;
    chk("ferr.data", rdd_a, 8'h5a);
`endif
    tick();

    // Reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      rxd_a = 8'h70 + 8'(i); rxr_a = 1'b1;
      tick();
    end
    rxr_a = 1'b0;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("midrst.count", cnt_a, 0);
    chk("midrst.ferr", fe_a, 0);
    wait_hello_a(lat);
    chk("midrst.hello", lat, 1);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
